div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit_pkg.sv | 41 ++++
 rtl/div_step.sv | 33 +++
 rtl/div_unit.sv | 161 ++++++++++++++++
 tb/tb_div_unit.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared CPU defines: ALU op codes, divider states and sizing
//
// Contents:
//   ALU_OP_*            8-bit ALU operation codes decoded in the ID stage
//   DIV_CYCLES_DEFAULT  iteration count of the 32-bit restoring divider
//   DIV_CNT_W           width of the divider iteration counter
//   div_state_e         divider FSM encoding
//   cond_neg()          two's-complement negate when requested
package div_unit_pkg;

  // ALU operation codes shared by decode and execute.
  localparam logic [7:0] ALU_OP_NOP   = 8'b0000_0000;
  localparam logic [7:0] ALU_OP_AND   = 8'b0010_0100;
  localparam logic [7:0] ALU_OP_OR    = 8'b0010_0101;
  localparam logic [7:0] ALU_OP_XOR   = 8'b0010_0110;
  localparam logic [7:0] ALU_OP_ADD   = 8'b0010_0000;
  localparam logic [7:0] ALU_OP_SUB   = 8'b0010_0010;
  localparam logic [7:0] ALU_OP_MULT  = 8'b0001_1000;
  localparam logic [7:0] ALU_OP_MULTU = 8'b0001_1001;
  localparam logic [7:0] ALU_OP_DIV   = 8'b0001_1010;
  localparam logic [7:0] ALU_OP_DIVU  = 8'b0001_1011;

  // One quotient bit per cycle for a 32-bit dividend.
  localparam int DIV_CYCLES_DEFAULT = 32;
  // Counter must reach DIV_CYCLES-1 = 31; one spare bit keeps the increment clean.
  localparam int DIV_CNT_W          = 6;

  typedef enum logic [1:0] {
    DIV_IDLE    = 2'd0,
    DIV_BY_ZERO = 2'd1,
    DIV_ON      = 2'd2,
    DIV_END     = 2'd3
  } div_state_e;

  // Negating 0x80000000 yields 0x80000000, which is also its correct
  // unsigned magnitude, so this doubles as the absolute-value helper.
  function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring shift-subtract step of the unsigned divider
//
// Ports:
//   rem_i      in  32  partial remainder before this step (always < divisor_i)
//   dvd_bit_i  in  1   next dividend bit shifted into the remainder
//   divisor_i  in  32  divisor magnitude (non-zero)
//   rem_o      out 32  partial remainder after this step
//   q_bit_o    out 1   quotient bit produced by this step
module div_step (
  input  logic [31:0] rem_i,
  input  logic        dvd_bit_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] rem_o,
  output logic        q_bit_o
);

  // The shifted remainder can need 33 bits when the divisor is above 2^31,
  // so the trial subtraction is 33 bits wide plus a borrow bit.
  logic [32:0] minuend;
  logic [33:0] trial;
  logic        unused_msb;

  always_comb begin
    minuend = {rem_i, dvd_bit_i};
    trial   = {1'b0, minuend} - {2'b00, divisor_i};
    q_bit_o = ~trial[33];
    // Either branch is below the divisor, so bit 32 is always zero here.
    rem_o   = trial[33] ? minuend[31:0] : trial[31:0];
  end

  assign unused_msb = trial[32] ^ minuend[32];

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle DIV/DIVU unit with annul and hi/lo result
//
// Ports:
//   clk         in  1   rising-edge clock
//   resetn      in  1   asynchronous reset, active low
//   start       in  1   request a divide (E-stage is_div)
//   signed_div  in  1   1 = DIV (signed), 0 = DIVU
//   opdata1     in  32  dividend (rs)
//   opdata2     in  32  divisor (rt)
//   annul       in  1   abort current operation (exception flush)
//   result      out 64  {hi = remainder, lo = quotient}, valid while ready
//   ready       out 1   one-cycle result-valid pulse
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] opdata1,
  input  logic [31:0] opdata2,
  input  logic        annul,
  output logic [63:0] result,
  output logic        ready
);

  localparam logic [DIV_CNT_W-1:0] LAST_STEP = DIV_CNT_W'(DIV_CYCLES - 1);

  div_state_e           state_q, state_d;
  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic                 signed_q, signed_d;
  logic                 dvd_neg_q, dvd_neg_d;
  logic                 dvs_neg_q, dvs_neg_d;
  // dvd_q starts as the dividend magnitude and is shifted left each step;
  // quotient bits enter at the bottom, so after the last step it holds
  // the quotient magnitude.
  logic [31:0]          dvd_q, dvd_d;
  logic [31:0]          dvs_q, dvs_d;
  logic [31:0]          rem_q, rem_d;
  logic [63:0]          result_q, result_d;
  logic                 ready_q, ready_d;

  logic [31:0]          step_rem;
  logic                 step_qbit;
  logic [31:0]          quot_next;
  logic                 neg_quot;
  logic                 neg_rem;

  div_step u_step (
    .rem_i     (rem_q),
    .dvd_bit_i (dvd_q[31]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_qbit)
  );

  assign quot_next = {dvd_q[30:0], step_qbit};
  // Quotient is negative when signs differ; remainder follows the dividend.
  assign neg_quot  = signed_q & (dvd_neg_q ^ dvs_neg_q);
  assign neg_rem   = signed_q & dvd_neg_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    signed_d  = signed_q;
    dvd_neg_d = dvd_neg_q;
    dvs_neg_d = dvs_neg_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    result_d  = result_q;
    ready_d   = 1'b0;

    case (state_q)
      DIV_IDLE: begin
        if (start) begin
          result_d = '0;
          if (opdata2 == 32'd0) begin
            state_d = DIV_BY_ZERO;
          end else begin
            signed_d  = signed_div;
            dvd_neg_d = signed_div & opdata1[31];
            dvs_neg_d = signed_div & opdata2[31];
            dvd_d     = cond_neg(opdata1, signed_div & opdata1[31]);
            dvs_d     = cond_neg(opdata2, signed_div & opdata2[31]);
            rem_d     = '0;
            cnt_d     = '0;
            state_d   = DIV_ON;
          end
        end
      end

      DIV_BY_ZERO: begin
        result_d = '0;
        ready_d  = 1'b1;
        state_d  = DIV_END;
      end

      DIV_ON: begin
        rem_d = step_rem;
        dvd_d = quot_next;
        cnt_d = cnt_q + DIV_CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          // 0x80000000 / -1 falls out naturally: magnitude 0x80000000
          // negates to itself, giving the required wrapped quotient.
          result_d = {cond_neg(step_rem, neg_rem), cond_neg(quot_next, neg_quot)};
          ready_d  = 1'b1;
          state_d  = DIV_END;
        end
      end

      DIV_END: begin
        state_d = DIV_IDLE;
      end

      default: begin
        state_d = DIV_IDLE;
      end
    endcase

    // Flush wins over everything, including a pending start or completion.
    if (annul) begin
      state_d  = DIV_IDLE;
      cnt_d    = '0;
      result_d = '0;
      ready_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      signed_q  <= 1'b0;
      dvd_neg_q <= 1'b0;
      dvs_neg_q <= 1'b0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      signed_q  <= signed_d;
      dvd_neg_q <= dvd_neg_d;
      dvs_neg_q <= dvs_neg_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result = result_q;
  assign ready  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking bench for div_unit
module tb_div_unit;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        signed_div = 1'b0;
  logic [31:0] opdata1 = '0;
  logic [31:0] opdata2 = '0;
  logic        annul = 1'b0;
  logic [63:0] result;
  logic        ready;

  int cyc = 0;
  int n_assert = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [63:0] res;
    int          due;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        sd;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;
  vec_t vecs[11];

  div_unit dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .signed_div (signed_div),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .annul      (annul),
    .result     (result),
    .ready      (ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] model(input logic sd, input logic [31:0] a, input logic [31:0] b);
    int signed sa, sbv, sq, sr;
    if (b == 32'd0) return 64'd0;
    if (!sd) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    sa  = a;
    sbv = b;
    sq  = sa / sbv;
    sr  = sa % sbv;
    return {32'(sr), 32'(sq)};
  endfunction

  // Scoreboard monitor: every ready pulse must match the oldest expectation
  // both in value and in the exact cycle it was due.
  always @(negedge clk) begin
    if (mon_en) begin
      if (ready !== 1'b0) begin
        if (sb.size() == 0) begin
          n_assert++;
          n_fail++;
          $display("FAIL spurious_ready: got ready=%b expected 0 (cycle %0d)", ready, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("result", result, e.res);
          chk("latency", 64'(cyc), 64'(e.due));
        end
      end else if (sb.size() > 0 && cyc > sb[0].due) begin
        n_assert++;
        n_fail++;
        $display("FAIL ready_timeout: got no ready expected one at cycle %0d (now %0d)", sb[0].due, cyc);
        void'(sb.pop_front());
      end
    end
  end

  task automatic push_exp(input logic [63:0] res, input int due);
    exp_t e;
    e.res = res;
    e.due = due;
    sb.push_back(e);
  endtask

  task automatic issue(input logic sd, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp);
    @(posedge clk); #1;
    signed_div = sd;
    opdata1    = a;
    opdata2    = b;
    start      = 1'b1;
    push_exp(exp, cyc + ((b == 32'd0) ? 2 : 33));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_assert++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("quiet_ready", 64'(ready), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1);
  end

  initial begin
    int s;
    logic        rsd;
    logic [31:0] ra, rb;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          64'h00000002_0000000E};
    vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          64'hFFFFFFFF_FFFFFFFD};
    vecs[2]  = '{1'b1, 32'd5,          32'd0,          64'h00000000_00000000};
    vecs[3]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  64'h00000000_80000000};
    vecs[4]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          64'h00000000_FFFFFFFF};
    vecs[5]  = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  64'h00000001_00000001};
    vecs[6]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  64'h00000001_FFFFFFFD};
    vecs[7]  = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  64'hFFFFFFFF_00000003};
    vecs[8]  = '{1'b0, 32'd3,          32'd10,         64'h00000003_00000000};
    vecs[9]  = '{1'b0, 32'hFFFF_FFF9,  32'd2,          64'h00000001_7FFFFFFC};
    vecs[10] = '{1'b0, 32'd5,          32'd0,          64'h00000000_00000000};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", 64'(ready), 64'd0);
    chk("reset_result", result, 64'd0);
    resetn = 1'b1;
    mon_en = 1'b1;

    // Directed vector table.
    foreach (vecs[i]) begin
      issue(vecs[i].sd, vecs[i].a, vecs[i].b, vecs[i].exp);
      drain();
    end

    // Random operands against the arithmetic model.
    for (int i = 0; i < 12; i++) begin
      rsd = 1'($urandom_range(0, 1));
      ra  = $urandom;
      rb  = (i % 3 == 0) ? 32'($urandom_range(1, 15)) : $urandom;
      if (i == 5) rb = 32'd0;
      issue(rsd, ra, rb, model(rsd, ra, rb));
      drain();
    end

    // Inputs and start toggling while ON must not disturb the divide.
    @(posedge clk); #1;
    signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7; start = 1'b1;
    push_exp(64'h00000002_0000000E, cyc + 33);
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      signed_div = 1'($urandom_range(0, 1));
      opdata1    = $urandom;
      opdata2    = $urandom;
      start      = 1'($urandom_range(0, 1));
    end
    start = 1'b0;
    drain();

    // Annul in cycle 10; the next cycle is IDLE and accepts a new divide.
    @(posedge clk); #1;
    signed_div = 1'b0; opdata1 = 32'h1234_5678; opdata2 = 32'd3; start = 1'b1;
    s = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    annul = 1'b1;
    @(posedge clk); #1;
    annul = 1'b0;
    chk("annul_cycle", 64'(cyc), 64'(s + 11));
    signed_div = 1'b0; opdata1 = 32'h10; opdata2 = 32'd4; start = 1'b1;
    push_exp(64'h00000000_00000004, cyc + 33);
    @(negedge clk);
    chk("annul_ready", 64'(ready), 64'd0);
    chk("annul_result", result, 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    drain();

    // Annul on the last ON cycle beats completion.
    @(posedge clk); #1;
    signed_div = 1'b1; opdata1 = 32'd77; opdata2 = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (31) @(posedge clk);
    #1;
    annul = 1'b1;
    @(posedge clk); #1;
    annul = 1'b0;
    quiet(40);

    // Annul together with start in IDLE: nothing is accepted.
    @(posedge clk); #1;
    signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7; start = 1'b1; annul = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; annul = 1'b0;
    quiet(40);

    // Back-to-back: start held across END is accepted again right after.
    @(posedge clk); #1;
    signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7; start = 1'b1;
    s = cyc;
    push_exp(64'h00000002_0000000E, s + 33);
    push_exp(64'h00000002_0000000E, s + 67);
    repeat (35) @(posedge clk);
    #1;
    start = 1'b0;
    drain();

    // Reset in cycle 20 of a divide, then start on the first edge after release.
    @(posedge clk); #1;
    signed_div = 1'b0; opdata1 = 32'hFFFF_FFFF; opdata2 = 32'd3; start = 1'b1;
    push_exp(64'h00000000_55555555, cyc + 33);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    resetn = 1'b0;
    sb.delete();
    #1;
    chk("rst_mid_ready", 64'(ready), 64'd0);
    chk("rst_mid_result", result, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    signed_div = 1'b0; opdata1 = 32'h10; opdata2 = 32'd4; start = 1'b1;
    push_exp(64'h00000000_00000004, cyc + 33);
    @(posedge clk); #1;
    start = 1'b0;
    drain();

    // Result holds after END until reset clears it asynchronously.
    @(negedge clk);
    chk("result_hold", result, 64'h00000000_00000004);
    #2;
    resetn = 1'b0;
    #1;
    chk("rst_hold_result", result, 64'd0);
    chk("rst_hold_ready", 64'(ready), 64'd0);
    #1;
    resetn = 1'b1;
    quiet(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
